// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx : 8N1/8N2 serial transmitter with a one-byte holding buffer.
//
// Bytes arrive over a req/cts handshake. A byte is accepted on any rising
// edge where i_req && o_cts. It is then shifted out LSB-first as
// start(0), 8 data bits, and stop_bits stop(1) periods. Each serial bit lasts
// cycles_per_bit clocks. The holding buffer is refilled while a frame is on
// the line, so consecutive frames follow each other with no idle gap.
//
// Parameters
//   cycles_per_bit : clocks per serial bit (>= 2)
//   stop_bits      : 1 or 2
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (aborts any frame, line high)
//   i_data   : byte offered by the upstream source
//   i_req    : i_data holds a valid byte
//   o_serial : registered TX line, idles high
//   o_cts    : holding buffer empty (registered decode, no path from i_req)
//   o_idle   : buffer empty and no frame in progress
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int cycles_per_bit = 4,
  parameter int stop_bits      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_req,
  output logic       o_serial,
  output logic       o_cts,
  output logic       o_idle
);

  // One counter serves both the per-bit period and the (longer) stop period.
  localparam int CW = $clog2(cycles_per_bit * stop_bits);
  localparam logic [CW-1:0] LIM_BIT  = CW'(cycles_per_bit - 1);
  localparam logic [CW-1:0] LIM_STOP = CW'(cycles_per_bit * stop_bits - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_bit_cycle;
  logic [CW-1:0]   w_bit_cycle_nxt;
  logic [2:0]      r_bit_index;
  logic [2:0]      w_bit_index_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_serial;
  logic            w_serial_nxt;
  logic            r_buf_valid;
  logic [7:0]      r_buf_data;

  logic            w_accept;
  logic            w_take;
  logic            w_bit_end;
  logic            w_stop_end;

  // Acceptance and shifter load are mutually exclusive: accept needs an
  // empty buffer, load needs a full one.
  assign w_accept   = i_req && !r_buf_valid;
  assign w_bit_end  = (r_bit_cycle == LIM_BIT);
  assign w_stop_end = (r_bit_cycle == LIM_STOP);

  assign o_serial = r_serial;
  assign o_cts    = !r_buf_valid;
  assign o_idle   = (r_state == IDLE) && !r_buf_valid;

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cycle_nxt = r_bit_cycle;
    w_bit_index_nxt = r_bit_index;
    w_shift_nxt     = r_shift;
    w_take          = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_buf_valid) begin
          w_take          = 1'b1;
          w_shift_nxt     = r_buf_data;
          w_bit_cycle_nxt = '0;
          w_state_nxt     = START;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_bit_cycle_nxt = '0;
          w_bit_index_nxt = 3'd0;
          w_state_nxt     = DATA;
        end else begin
          w_bit_cycle_nxt = r_bit_cycle + 1'b1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_bit_cycle_nxt = '0;
          if (r_bit_index == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt     = {1'b0, r_shift[7:1]};
            w_bit_index_nxt = r_bit_index + 3'd1;
          end
        end else begin
          w_bit_cycle_nxt = r_bit_cycle + 1'b1;
        end
      end

      STOP: begin
        if (w_stop_end) begin
          w_bit_cycle_nxt = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (r_buf_valid) begin
            w_take      = 1'b1;
            w_shift_nxt = r_buf_data;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_bit_cycle_nxt = r_bit_cycle + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Line value is derived from the next state so the registered output
    // lines up exactly with the state it belongs to.
    case (w_state_nxt)
      START:   w_serial_nxt = 1'b0;
      DATA:    w_serial_nxt = w_shift_nxt[0];
      default: w_serial_nxt = 1'b1;
    endcase
  end

  // Control state: cleared asynchronously so a reset kills a frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cycle <= '0;
      r_bit_index <= 3'd0;
      r_serial    <= 1'b1;
      r_buf_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cycle <= w_bit_cycle_nxt;
      r_bit_index <= w_bit_index_nxt;
      r_serial    <= w_serial_nxt;
      if (w_accept) begin
        r_buf_valid <= 1'b1;
      end else if (w_take) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  // Datapath: contents only matter while the matching control bit says so.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_data <= i_data;
    end
    r_shift <= w_shift_nxt;
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_req;
  logic       o_serial;
  logic       o_cts;
  logic       o_idle;

  logic [7:0] i_data2;
  logic       i_req2;
  logic       o_serial2;
  logic       o_cts2;
  logic       o_idle2;

  int total;
  int bad;

  uart_tx #(.cycles_per_bit(4), .stop_bits(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (i_data),
    .i_req    (i_req),
    .o_serial (o_serial),
    .o_cts    (o_cts),
    .o_idle   (o_idle)
  );

  uart_tx #(.cycles_per_bit(3), .stop_bits(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_data   (i_data2),
    .i_req    (i_req2),
    .o_serial (o_serial2),
    .o_cts    (o_cts2),
    .o_idle   (o_idle2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles after the start bit begins.
  function automatic logic exp_line(input logic [7:0] b, input int k, input int cpb);
    if (k < cpb) return 1'b0;
    else if (k < 9 * cpb) return b[(k - cpb) / cpb];
    else return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_data  = 8'h00;
    i_req2  = 1'b0;
    i_data2 = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_serial !== 1'b1) begin bad++; $display("FAIL reset_serial got=%b exp=1", o_serial); end
    total++; if (o_cts !== 1'b1) begin bad++; $display("FAIL reset_cts got=%b exp=1", o_cts); end
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", o_idle); end
    total++; if (o_serial2 !== 1'b1) begin bad++; $display("FAIL reset_serial2 got=%b exp=1", o_serial2); end
    total++; if (o_cts2 !== 1'b1) begin bad++; $display("FAIL reset_cts2 got=%b exp=1", o_cts2); end
    total++; if (o_idle2 !== 1'b1) begin bad++; $display("FAIL reset_idle2 got=%b exp=1", o_idle2); end
  endtask

  task automatic test_single(input logic [7:0] b);
    @(negedge clk);
    i_data = b;
    i_req  = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    total++; if (o_cts !== 1'b0) begin bad++; $display("FAIL single_cts_low got=%b exp=0", o_cts); end
    total++; if (o_idle !== 1'b0) begin bad++; $display("FAIL single_idle_fall got=%b exp=0", o_idle); end
    total++; if (o_serial !== 1'b1) begin bad++; $display("FAIL single_latency_line got=%b exp=1", o_serial); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      total++;
      if (o_serial !== exp_line(b, k, 4)) begin
        bad++; $display("FAIL single_line byte=%h k=%0d got=%b exp=%b", b, k, o_serial, exp_line(b, k, 4));
      end
      total++;
      if (o_idle !== 1'b0) begin bad++; $display("FAIL single_idle_busy k=%0d got=%b exp=0", k, o_idle); end
      total++;
      if (o_cts !== 1'b1) begin bad++; $display("FAIL single_cts_high k=%0d got=%b exp=1", k, o_cts); end
    end
    @(negedge clk);
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL single_idle_rise got=%b exp=1", o_idle); end
    total++; if (o_serial !== 1'b1) begin bad++; $display("FAIL single_line_after got=%b exp=1", o_serial); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = 8'h48;
    b1 = 8'h65;
    @(negedge clk);
    i_data = b0;
    i_req  = 1'b1;
    @(negedge clk);
    i_data = b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++; if (o_cts !== 1'b1) begin bad++; $display("FAIL b2b_cts_free got=%b exp=1", o_cts); end
      end
      if (k == 1) begin
        total++; if (o_cts !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b exp=0", o_cts); end
        i_req = 1'b0;
      end
      total++;
      if (o_serial !== ((k < 40) ? exp_line(b0, k, 4) : exp_line(b1, k - 40, 4))) begin
        bad++; $display("FAIL b2b_line k=%0d got=%b", k, o_serial);
      end
      total++;
      if (o_idle !== 1'b0) begin bad++; $display("FAIL b2b_idle k=%0d got=%b exp=0", k, o_idle); end
    end
    @(negedge clk);
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL b2b_idle_end got=%b exp=1", o_idle); end
  endtask

  task automatic test_cts_hold;
    logic [7:0] ba;
    logic [7:0] bb;
    logic [7:0] bc;
    logic       e;
    // Data pattern presented before edge n is 8'(n*37+5); accepts land on
    // edges 0, 2 and 42.
    ba = 8'(0 * 37 + 5);
    bb = 8'(2 * 37 + 5);
    bc = 8'(42 * 37 + 5);
    for (int n = 0; n <= 122; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 122) begin
        if (n - 2 < 40)      e = exp_line(ba, n - 2, 4);
        else if (n - 2 < 80) e = exp_line(bb, n - 42, 4);
        else                 e = exp_line(bc, n - 82, 4);
        total++;
        if (o_serial !== e) begin bad++; $display("FAIL hold_line n=%0d got=%b exp=%b", n, o_serial, e); end
      end
      if (n == 3) begin
        total++; if (o_cts !== 1'b0) begin bad++; $display("FAIL hold_cts_full got=%b exp=0", o_cts); end
      end
      if (n == 42) begin
        total++; if (o_cts !== 1'b1) begin bad++; $display("FAIL hold_cts_rise got=%b exp=1", o_cts); end
      end
      if (n == 43) begin
        total++; if (o_cts !== 1'b0) begin bad++; $display("FAIL hold_cts_refill got=%b exp=0", o_cts); end
      end
      if (n == 122) begin
        total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL hold_idle_end got=%b exp=1", o_idle); end
        total++; if (o_serial !== 1'b1) begin bad++; $display("FAIL hold_line_end got=%b exp=1", o_serial); end
      end
      i_data = 8'(n * 37 + 5);
      i_req  = (n <= 42);
    end
    i_req = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    i_data = 8'hA7;
    i_req  = 1'b1;
    @(negedge clk);
    i_data = 8'h99;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++; if (o_cts !== 1'b0) begin bad++; $display("FAIL areset_buffered got=%b exp=0", o_cts); end
        i_req = 1'b0;
      end
      total++;
      if (o_serial !== exp_line(8'hA7, k, 4)) begin
        bad++; $display("FAIL areset_line k=%0d got=%b exp=%b", k, o_serial, exp_line(8'hA7, k, 4));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (o_serial !== 1'b1) begin bad++; $display("FAIL areset_serial got=%b exp=1", o_serial); end
    total++; if (o_cts !== 1'b1) begin bad++; $display("FAIL areset_cts got=%b exp=1", o_cts); end
    total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL areset_idle got=%b exp=1", o_idle); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_single(8'h3C);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (o_serial !== 1'b1 || o_idle !== 1'b1) begin
        bad++; $display("FAIL areset_residue k=%0d serial=%b idle=%b exp=1,1", k, o_serial, o_idle);
      end
    end
  endtask

  task automatic test_stop2;
    @(negedge clk);
    i_data2 = 8'hFF;
    i_req2  = 1'b1;
    @(negedge clk);
    i_req2 = 1'b0;
    total++; if (o_cts2 !== 1'b0) begin bad++; $display("FAIL stop2_cts got=%b exp=0", o_cts2); end
    total++; if (o_serial2 !== 1'b1) begin bad++; $display("FAIL stop2_latency got=%b exp=1", o_serial2); end
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      total++;
      if (o_serial2 !== exp_line(8'hFF, k, 3)) begin
        bad++; $display("FAIL stop2_line k=%0d got=%b exp=%b", k, o_serial2, exp_line(8'hFF, k, 3));
      end
      total++;
      if (o_idle2 !== 1'b0) begin bad++; $display("FAIL stop2_idle_busy k=%0d got=%b exp=0", k, o_idle2); end
    end
    @(negedge clk);
    total++; if (o_idle2 !== 1'b1) begin bad++; $display("FAIL stop2_idle_end got=%b exp=1", o_idle2); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single(8'h55);
    test_back_to_back();
    test_cts_hold();
    test_async_reset();
    test_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
